mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style main controller for the multicycle MIPS datapath.
- Sequences the shared ALU, which is used for PC+4, branch target, address calculation and execute, and drives the 3-bit ALUctrl code (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT).
- Also drives the memory, instruction-register, register-file and PC enables.
- Sits between the instruction register (Op/Funct) and the datapath muxes.

Parameters:
MEM_LAT, 0, extra wait cycles held in FETCH, MEMRD and MEMWR (0..15) for slow memory.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
Op  input  6  IR[31:26]
Funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
PCWrite  output  1  PC load enable (includes branch qualification)
IorD  output  1  memory address select (0 = PC, 1 = ALUOut)
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load enable
RegDst  output  1  write register select (1 = rd, 0 = rt)
MemtoReg  output  1  write data select (1 = MDR)
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select (0 = PC, 1 = reg A)
ALUSrcB  output  2  ALU B select (00 = reg B, 01 = 4, 10 = SignImm, 11 = SignImm<<2)
ALUctrl  output  3  ALU operation code
PCSrc  output  2  PC source (00 = ALUResult, 01 = ALUOut, 10 = jump target)
state  output  4  current state, for debug and verification

Behaviour:
- State encoding: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12. Codes 13-15 are illegal and go to FETCH on the next edge.
- rst asserted: state=RST and wait counter=0 immediately, asynchronously. All outputs are 0 while in RST.
- Reset may arrive mid-instruction. Any in-flight write strobe drops combinationally when rst asserts.
- RST -> FETCH on the first edge after rst deasserts.
- Outputs are a combinational decode of state (plus Funct in EXEC, zero in BRANCH). Any signal not listed for a state is 0.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctrl=0, PCSrc=00.
  - IRWrite=1 and PCWrite=1 on the final FETCH cycle only.
  - Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUctrl=0. Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other Op -> FETCH (executes as a NOP)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUctrl=0. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Goes to MEMWB after the final cycle.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1 for every cycle spent in the state. Goes to FETCH after the final cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUctrl from Funct:
  - 100000 -> 0
  - 100010 -> 1
  - 100100 -> 2
  - 100101 -> 3
  - 101010 -> 4
  - any other Funct -> 0
  - Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUctrl=1, PCSrc=01, PCWrite=zero. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUctrl=0. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- Wait counter:
  - 4 bits; cleared on entry to every state.
  - FETCH, MEMRD and MEMWR each occupy MEM_LAT+1 cycles. The final cycle is the one where counter==MEM_LAT; the counter increments otherwise.
  - With MEM_LAT=0 there are no stalls.
- Latency with MEM_LAT=0, counted in cycles from FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown Op 2.

Optional Feature:
BNE_EN
- Defined:
  - Op 000101 (bne) decodes to BRANCH.
  - In BRANCH, PCWrite=~zero for bne and PCWrite=zero for beq. The distinction uses Op, which is held stable by IR.
  - Adds output BadOp (1 bit, reset 0): a registered sticky flag set when DECODE sees an unsupported Op or EXEC sees an unsupported Funct; cleared only by rst.
- Undefined: bne is treated as an unknown Op (NOP path); no BadOp port exists.

Test Plan:
- rst=1 mid-MEMWR (MemWrite=1) -> state=0 and all outputs 0 in the same cycle. After release: state sequence 1,2 and IRWrite pulses once.
- lw (Op=100011), MEM_LAT=0 -> states 1,2,3,4,5,1. RegWrite=1 with MemtoReg=1, RegDst=0 only in state 5. ALUctrl=0 in states 1-3.
- R-type sub (Op=0, Funct=100010) -> EXEC drives ALUctrl=1, ALUSrcA=1, ALUSrcB=00. ALUWB drives RegDst=1, RegWrite=1. Repeat for Funct=101010 -> ALUctrl=4.
- beq with zero=1 -> PCWrite=1, PCSrc=01, ALUctrl=1 in state 9. With zero=0 -> PCWrite=0. Next state 1 in both cases.
- MEM_LAT=2, sw -> FETCH lasts 3 cycles with IRWrite/PCWrite only on the 3rd. MEMWR lasts 3 cycles with MemWrite=1 throughout, then FETCH.
- Op=111111 -> states 1,2,1 and no write strobes. With BNE_EN: BadOp=1 and it stays 1. Op=000101 with zero=0 -> PCWrite=1 in BRANCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Moore-style main controller for the multicycle MIPS datapath.
//            Sequences the shared ALU (PC+4, branch target, address calc,
//            execute) and drives memory / IR / register-file / PC enables.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_LAT  extra wait cycles held in FETCH, MEMRD and MEMWR (0..15)
// Optional build macro:
//   BNE_EN   adds bne decode (Op 000101) and the sticky BadOp output
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   Op, Funct         IR[31:26], IR[5:0]
//   zero              ALU zero flag (branch qualification)
//   PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUctrl[2:0], PCSrc[1:0]   datapath controls
//   state[3:0]        current state code, for debug
//   BadOp             (BNE_EN only) sticky unsupported Op/Funct flag
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUctrl,
  output logic [1:0] PCSrc,
`ifdef BNE_EN
  output logic       BadOp,
`endif
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [3:0] C_LAT      = 4'(MEM_LAT);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_last;
  logic w_op_mem;
  logic w_op_branch;
  logic w_op_known;
  logic w_funct_known;

  // Final cycle of a memory-wait state; states without waits never look at it.
  assign w_last   = (r_cnt == C_LAT);
  assign w_op_mem = (Op == C_OP_LW) || (Op == C_OP_SW);
`ifdef BNE_EN
  assign w_op_branch = (Op == C_OP_BEQ) || (Op == C_OP_BNE);
`else
  assign w_op_branch = (Op == C_OP_BEQ);
`endif
  assign w_op_known = w_op_mem || w_op_branch || (Op == C_OP_RTYPE) ||
                      (Op == C_OP_ADDI) || (Op == C_OP_J);
  assign w_funct_known = (Funct == 6'b100000) || (Funct == 6'b100010) ||
                         (Funct == 6'b100100) || (Funct == 6'b100101) ||
                         (Funct == 6'b101010);

`ifdef BNE_EN
  logic r_badop;
  assign BadOp = r_badop;
`endif

  // State register, wait counter and (optionally) the sticky BadOp flag.
  // The counter is cleared on every transition and only advances while a
  // memory-wait state is being held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
      r_cnt   <= 4'd0;
`ifdef BNE_EN
      r_badop <= 1'b0;
`endif
    end else begin
      r_cnt <= 4'd0;
      case (r_state)
        S_RST:    r_state <= S_FETCH;
        S_FETCH: begin
          if (w_last) r_state <= S_DECODE;
          else        r_cnt   <= r_cnt + 4'd1;
        end
        S_DECODE: begin
          if (w_op_mem)                r_state <= S_MEMADR;
          else if (Op == C_OP_RTYPE)   r_state <= S_EXEC;
          else if (w_op_branch)        r_state <= S_BRANCH;
          else if (Op == C_OP_ADDI)    r_state <= S_ADDIEX;
          else if (Op == C_OP_J)       r_state <= S_JUMP;
          else                         r_state <= S_FETCH;
`ifdef BNE_EN
          if (!w_op_known) r_badop <= 1'b1;
`endif
        end
        // Op is still held by IR, so it selects load vs store here.
        S_MEMADR: r_state <= (Op == C_OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (w_last) r_state <= S_MEMWB;
          else        r_cnt   <= r_cnt + 4'd1;
        end
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR: begin
          if (w_last) r_state <= S_FETCH;
          else        r_cnt   <= r_cnt + 4'd1;
        end
        S_EXEC: begin
          r_state <= S_ALUWB;
`ifdef BNE_EN
          if (!w_funct_known) r_badop <= 1'b1;
`endif
        end
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;  // codes 13-15 recover via FETCH
      endcase
    end
  end

  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_branch_take;

`ifdef BNE_EN
  assign w_branch_take = (Op == C_OP_BNE) ? ~zero : zero;
`else
  assign w_branch_take = zero;
`endif

  // Moore decode of the current state.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUctrl    = 3'd0;
    PCSrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = w_last;
        w_pcwrite = w_last;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUctrl = 3'd1;
          6'b100100: ALUctrl = 3'd2;
          6'b100101: ALUctrl = 3'd3;
          6'b101010: ALUctrl = 3'd4;
          default:   ALUctrl = 3'd0;
        endcase
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUctrl   = 3'd1;
        PCSrc     = 2'b01;
        w_pcwrite = w_branch_take;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are also gated by rst so they drop in the same instant
  // reset arrives, independent of the state register's clear-to-output path.
  assign PCWrite  = w_pcwrite  & ~rst;
  assign MemWrite = w_memwrite & ~rst;
  assign IRWrite  = w_irwrite  & ~rst;
  assign RegWrite = w_regwrite & ~rst;
  assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Self-checking bench for mips_multicycle_ctrl. Two instances,
//            MEM_LAT=0 and MEM_LAT=2, are exercised one at a time (the idle
//            one is held in reset) against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regdst;
    logic       m2r;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst2;
  logic [5:0] Op, Funct;
  logic       zero;

  logic       pcw0, iord0, memw0, irw0, rdst0, m2r0, regw0, srca0;
  logic [1:0] srcb0, pcsrc0;
  logic [2:0] aluc0;
  logic [3:0] st0;
  logic       pcw2, iord2, memw2, irw2, rdst2, m2r2, regw2, srca2;
  logic [1:0] srcb2, pcsrc2;
  logic [2:0] aluc2;
  logic [3:0] st2;
`ifdef BNE_EN
  logic       bad0, bad2;
`endif

  ctl_t act0, act2;
  assign act0 = {pcw0, iord0, memw0, irw0, rdst0, m2r0, regw0, srca0, srcb0, aluc0, pcsrc0};
  assign act2 = {pcw2, iord2, memw2, irw2, rdst2, m2r2, regw2, srca2, srcb2, aluc2, pcsrc2};

  mips_multicycle_ctrl #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst0), .Op(Op), .Funct(Funct), .zero(zero),
    .PCWrite(pcw0), .IorD(iord0), .MemWrite(memw0), .IRWrite(irw0),
    .RegDst(rdst0), .MemtoReg(m2r0), .RegWrite(regw0), .ALUSrcA(srca0),
    .ALUSrcB(srcb0), .ALUctrl(aluc0), .PCSrc(pcsrc0),
`ifdef BNE_EN
    .BadOp(bad0),
`endif
    .state(st0)
  );

  mips_multicycle_ctrl #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst2), .Op(Op), .Funct(Funct), .zero(zero),
    .PCWrite(pcw2), .IorD(iord2), .MemWrite(memw2), .IRWrite(irw2),
    .RegDst(rdst2), .MemtoReg(m2r2), .RegWrite(regw2), .ALUSrcA(srca2),
    .ALUSrcB(srcb2), .ALUctrl(aluc2), .PCSrc(pcsrc2),
`ifdef BNE_EN
    .BadOp(bad2),
`endif
    .state(st2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit bad_m[2];          // expected BadOp per instance (index 0 fast, 1 slow)
  int exp_st[$];         // expected state per cycle of one instruction
  bit exp_fin[$];        // 1 on the last cycle of a held memory state

  function automatic bit op_is_branch(input logic [5:0] op);
`ifdef BNE_EN
    return (op == 6'b000100) || (op == 6'b000101);
`else
    return (op == 6'b000100);
`endif
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b001000 || op == 6'b000010 || op_is_branch(op);
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'h20: return 3'd0;
      6'h22: return 3'd1;
      6'h24: return 3'd2;
      6'h25: return 3'd3;
      6'h2A: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Control word expected for a given state of the instruction flow.
  function automatic ctl_t model_out(input int st, input bit fin, input logic [5:0] op,
                                     input logic [5:0] f, input bit z);
    ctl_t c = '0;
    case (st)
      1:  begin c.srcb = 2'b01; c.irw = fin; c.pcw = fin; end
      2:  c.srcb = 2'b11;
      3:  begin c.srca = 1; c.srcb = 2'b10; end
      4:  c.iord = 1;
      5:  begin c.m2r = 1; c.regw = 1; end
      6:  begin c.iord = 1; c.memw = 1; end
      7:  begin c.srca = 1; c.aluc = alu_of_funct(f); end
      8:  begin c.regdst = 1; c.regw = 1; end
      9:  begin
            c.srca = 1; c.aluc = 3'd1; c.pcsrc = 2'b01;
            c.pcw = (op == 6'b000101) ? ~z : z;
          end
      10: begin c.srca = 1; c.srcb = 2'b10; end
      11: c.regw = 1;
      12: begin c.pcsrc = 2'b10; c.pcw = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push_held(input int st, input int lat);
    for (int i = 0; i <= lat; i++) begin
      exp_st.push_back(st);
      exp_fin.push_back(i == lat);
    end
  endtask

  task automatic build_seq(input logic [5:0] op, input int lat);
    exp_st.delete();
    exp_fin.delete();
    push_held(1, lat);
    exp_st.push_back(2); exp_fin.push_back(1);
    if (op == 6'b100011) begin
      exp_st.push_back(3); exp_fin.push_back(1);
      push_held(4, lat);
      exp_st.push_back(5); exp_fin.push_back(1);
    end else if (op == 6'b101011) begin
      exp_st.push_back(3); exp_fin.push_back(1);
      push_held(6, lat);
    end else if (op == 6'b000000) begin
      exp_st.push_back(7); exp_fin.push_back(1);
      exp_st.push_back(8); exp_fin.push_back(1);
    end else if (op_is_branch(op)) begin
      exp_st.push_back(9); exp_fin.push_back(1);
    end else if (op == 6'b001000) begin
      exp_st.push_back(10); exp_fin.push_back(1);
      exp_st.push_back(11); exp_fin.push_back(1);
    end else if (op == 6'b000010) begin
      exp_st.push_back(12); exp_fin.push_back(1);
    end
  endtask

  // Runs one whole instruction; entered #1 after the edge that put the
  // selected instance into its first FETCH cycle, leaves it the same way.
  task automatic run_instr(input string tag, input bit slow, input logic [5:0] op,
                           input logic [5:0] f, input bit z,
                           output int n_irw, output int n_memw, output int n_regw,
                           output int n_pcw);
    ctl_t act, exp;
    logic [3:0] st;
    n_irw = 0; n_memw = 0; n_regw = 0; n_pcw = 0;
    Op = op; Funct = f; zero = z;
    build_seq(op, slow ? 2 : 0);
    for (int i = 0; i < exp_st.size(); i++) begin
      @(negedge clk);
      act = slow ? act2 : act0;
      st  = slow ? st2  : st0;
      exp = model_out(exp_st[i], exp_fin[i], op, f, z);
      n_irw  += int'(act.irw);
      n_memw += int'(act.memw);
      n_regw += int'(act.regw);
      n_pcw  += int'(act.pcw);
      n_checks++;
      if (st !== 4'(exp_st[i])) begin
        n_fail++;
        $display("FAIL %s state dut%0d cyc %0d: got %0d want %0d", tag, slow ? 2 : 0, i, st, exp_st[i]);
      end
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s ctl dut%0d cyc %0d st %0d: got %h want %h", tag, slow ? 2 : 0, i, exp_st[i], act, exp);
      end
`ifdef BNE_EN
      n_checks++;
      if ((slow ? bad2 : bad0) !== bad_m[slow]) begin
        n_fail++;
        $display("FAIL %s BadOp dut%0d cyc %0d: got %b want %b", tag, slow ? 2 : 0, i, slow ? bad2 : bad0, bad_m[slow]);
      end
      if (exp_st[i] == 2 && !op_known(op)) bad_m[slow] = 1'b1;
      if (exp_st[i] == 7 && (f != 6'h20 && f != 6'h22 && f != 6'h24 && f != 6'h25 && f != 6'h2A))
        bad_m[slow] = 1'b1;
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst0 = 1; rst2 = 1; Op = 0; Funct = 0; zero = 0;
    #2;
    n_checks++;
    if (st0 !== 4'd0 || act0 !== '0) begin
      n_fail++; $display("FAIL reset dut0: state %0d ctl %h, want 0 0", st0, act0);
    end
    n_checks++;
    if (st2 !== 4'd0 || act2 !== '0) begin
      n_fail++; $display("FAIL reset dut2: state %0d ctl %h, want 0 0", st2, act2);
    end
    bad_m[0] = 0; bad_m[1] = 0;
    @(negedge clk); rst0 = 0;
    @(posedge clk); #1;
    n_checks++;
    if (st0 !== 4'd1) begin
      n_fail++; $display("FAIL reset_exit: state %0d want 1", st0);
    end
  endtask

  task automatic test_lw;
    int a, b, c, d;
    run_instr("lw", 0, 6'b100011, 6'($urandom), 1'($urandom), a, b, c, d);
    n_checks++;
    if (c !== 1) begin n_fail++; $display("FAIL lw_regwrite_count: got %0d want 1", c); end
  endtask

  task automatic test_rtype;
    int a, b, c, d;
    run_instr("sub", 0, 6'b000000, 6'b100010, 1'($urandom), a, b, c, d);
    run_instr("slt", 0, 6'b000000, 6'b101010, 1'($urandom), a, b, c, d);
    run_instr("and", 0, 6'b000000, 6'b100100, 0, a, b, c, d);
    run_instr("or",  0, 6'b000000, 6'b100101, 0, a, b, c, d);
    run_instr("addi", 0, 6'b001000, 6'($urandom), 0, a, b, c, d);
    run_instr("j",    0, 6'b000010, 6'($urandom), 0, a, b, c, d);
  endtask

  task automatic test_branch;
    int a, b, c, d;
    run_instr("beq_z1", 0, 6'b000100, 6'($urandom), 1, a, b, c, d);
    n_checks++;
    if (d !== 2) begin n_fail++; $display("FAIL beq_taken_pcwrites: got %0d want 2", d); end
    run_instr("beq_z0", 0, 6'b000100, 6'($urandom), 0, a, b, c, d);
    n_checks++;
    if (d !== 1) begin n_fail++; $display("FAIL beq_not_taken_pcwrites: got %0d want 1", d); end
    run_instr("bne_z0", 0, 6'b000101, 6'($urandom), 0, a, b, c, d);
  endtask

  task automatic test_unknown_op;
    int a, b, c, d;
    run_instr("badop", 0, 6'b111111, 6'($urandom), 1'($urandom), a, b, c, d);
    n_checks++;
    if (b + c !== 0) begin n_fail++; $display("FAIL badop_strobes: got %0d want 0", b + c); end
    run_instr("after_badop", 0, 6'b000100, 6'($urandom), 1, a, b, c, d);
  endtask

  task automatic test_reset_mid_memwr;
    int a, b, c, d;
    Op = 6'b101011; Funct = 0; zero = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (st0 !== 4'd6 || memw0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_memwr: state %0d MemWrite %b want 6 1", st0, memw0);
    end
    @(negedge clk); #1;
    rst0 = 1;
    #1;
    n_checks++;
    if (st0 !== 4'd0 || act0 !== '0) begin
      n_fail++; $display("FAIL mid_reset: state %0d ctl %h want 0 0", st0, act0);
    end
    bad_m[0] = 0;
    @(negedge clk); rst0 = 0;
    @(posedge clk); #1;
    run_instr("post_reset", 0, 6'b110011, 6'($urandom), 0, a, b, c, d);
    n_checks++;
    if (a !== 1) begin n_fail++; $display("FAIL post_reset_irwrite: got %0d want 1", a); end
  endtask

  task automatic test_slow_sw;
    int a, b, c, d;
    @(negedge clk); rst0 = 1; rst2 = 0;
    @(posedge clk); #1;
    run_instr("slow_sw", 1, 6'b101011, 6'($urandom), 1'($urandom), a, b, c, d);
    n_checks++;
    if (a !== 1 || b !== 3) begin
      n_fail++; $display("FAIL slow_sw_strobes: IRWrite %0d MemWrite %0d want 1 3", a, b);
    end
    run_instr("slow_lw", 1, 6'b100011, 6'($urandom), 0, a, b, c, d);
  endtask

  task automatic test_random(input bit slow, input int n);
    logic [5:0] ops[9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                           6'b001000, 6'b000010, 6'b111111, 6'b000000};
    logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    logic [5:0] op, f;
    int a, b, c, d;
    for (int k = 0; k < n; k++) begin
      op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      f  = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr("rand", slow, op, f, 1'($urandom), a, b, c, d);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_unknown_op();
    test_reset_mid_memwr();
    test_random(0, 40);
    test_slow_sw();
    test_random(1, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
